mcpu_ctrl: RTL
==============

Name: mcpu_ctrl

Overview:
Multi-cycle RV32I control unit, next generation of the single-cycle controller. Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states. Stalls on the memory/IO handshake (MIO_ready) for a bounded number of cycles. Decodes the full RV32I integer set (adds shifts, SLTU, LUI, AUIPC, JALR) into a 4-bit ALU code and drives PC/IR/register-file enables for the multi-cycle datapath.

Parameters:
ALUC_W, 4, ALU_Control width; must be at least 4.
WAIT_MAX, 15, max cycles a memory access may wait for MIO_ready before a bus error.
WAIT_W, 4, width of the wait counter; satisfies 2^WAIT_W > WAIT_MAX.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  synchronous reset, active-low.
OPcode  in  5  inst[6:2].
Fun3  in  3  inst[14:12].
Fun7  in  1  inst[30].
MIO_ready  in  1  memory/IO access complete this cycle.
CPU_MIO  out  1  memory/IO request valid.
MemRW  out  1  1 = write, 0 = read; meaningful only while CPU_MIO = 1.
IRWrite  out  1  latch instruction register.
PCWrite  out  1  unconditional PC update.
Branch  out  1  conditional PC update; datapath gates it with the compare result.
Jump  out  2  PC source: 00 = PC+4, 01 = PC+imm (JAL/branch), 10 = rs1+imm (JALR).
ImmSel  out  3  000 = I, 001 = S, 010 = B, 011 = J, 100 = U.
ALUSrc_A  out  2  00 = rs1, 01 = PC, 10 = zero.
ALUSrc_B  out  1  0 = rs2, 1 = imm.
ALU_Control  out  ALUC_W  operation code (see Decomposition).
MemtoReg  out  2  00 = ALU, 01 = memory, 10 = PC+4.
RegWrite  out  1  register-file write enable.
illegal  out  1  sticky: unsupported opcode was decoded.
bus_err  out  1  sticky: memory wait timed out.

Behaviour:
- Reset (rst_n = 0 at clk edge): state = FETCH, wait counter = 0, illegal = bus_err = 0. All enables and CPU_MIO are 0 in the reset cycle. Reset mid-access abandons the access; no write or enable is issued after reset.
- Outputs are a registered state decoded combinationally. Every enable not listed for a state is 0.
- FETCH: CPU_MIO = 1, MemRW = 0.
  - On MIO_ready: IRWrite = 1, PCWrite = 1, Jump = 00 in that same cycle; next state DECODE.
  - Otherwise stay in FETCH.
- DECODE: one cycle, no enables. Dispatch on OPcode:
  - 01100 (R) or 00100 (I-ALU), 01101 (LUI), 00101 (AUIPC) -> EXEC.
  - 00000 (load), 01000 (store) -> EXEC.
  - 11000 (branch), 11011 (JAL), 11001 (JALR) -> EXEC.
  - Any other opcode -> TRAP with illegal set.
- EXEC:
  - R-type: ALUSrc_B = 0, ALU code from {Fun7, Fun3}.
  - I-ALU: ALUSrc_B = 1, ImmSel = I. Fun7 is honoured only for Fun3 = 101 (SRAI vs SRLI); ADDI ignores Fun7.
  - LUI: ALUSrc_A = zero, ImmSel = U, ADD.
  - AUIPC: ALUSrc_A = PC, ImmSel = U, ADD.
  - The four cases above go to WB.
  - Load/store: ADD, imm (I or S); next state MEM.
  - Branch: ImmSel = B, Branch = 1, Jump = 01, ALU = SUB for BEQ/BNE/BLT/BGE and SLTU for BLTU/BGEU; next state FETCH.
  - JAL: Jump = 01, ImmSel = J, PCWrite = 1, RegWrite = 1, MemtoReg = 10; next state FETCH.
  - JALR: Jump = 10, ImmSel = I, PCWrite = 1, RegWrite = 1, MemtoReg = 10; next state FETCH.
- MEM: CPU_MIO = 1, MemRW = 1 for store. Outputs hold stable until MIO_ready.
  - On ready: load -> WB, store -> FETCH.
- WB: RegWrite = 1, MemtoReg = 01 for load, otherwise 00; next state FETCH.
- Wait counter:
  - Clears on entry to FETCH or MEM and on MIO_ready.
  - Increments on each cycle of CPU_MIO = 1 with MIO_ready = 0.
  - If MIO_ready = 0 when the counter equals WAIT_MAX: set bus_err, go to TRAP.
  - MIO_ready arriving in that same cycle wins; no error is raised.
- TRAP: all enables 0, CPU_MIO = 0. Exit only by reset.
- Latency with MIO_ready tied high: R/I/LUI/AUIPC = 4 cycles, load = 5, store = 4, branch/JAL/JALR = 3.

Decomposition:
- Package mcpu_pkg holds:
  - State encoding: FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4, TRAP = 5.
  - Opcode constants.
  - ALU codes: ADD = 0, SUB = 1, AND = 2, OR = 3, XOR = 4, SLT = 5, SLTU = 6, SLL = 7, SRL = 8, SRA = 9.
  - ImmSel, Jump and MemtoReg encodings.
- One sub-module, mcpu_alu_dec: purely combinational map of {class, Fun3, Fun7} to ALU code.

Test Plan:
- MIO_ready tied 1, R-type SUB (OPcode 01100, Fun3 000, Fun7 1) -> states F, D, E, W. ALU_Control = 1 in EXEC; RegWrite = 1 only in WB; total 4 cycles.
- Load, with MIO_ready low for 3 cycles during MEM -> CPU_MIO = 1 and MemRW = 0 held 4 cycles; WB asserts MemtoReg = 01 and RegWrite = 1; bus_err = 0.
- Store with MIO_ready never asserted, WAIT_MAX = 15 -> bus_err rises after 16 MEM cycles; state = TRAP; MemRW and CPU_MIO then 0.
- SRAI (OPcode 00100, Fun3 101, Fun7 1) -> ALU_Control = 9. ADDI with Fun7 = 1 -> ALU_Control = 0.
- JALR -> in EXEC: Jump = 10, PCWrite = 1, RegWrite = 1, MemtoReg = 10; back to FETCH next cycle.
- OPcode 11111 -> illegal = 1 after DECODE and stays in TRAP. rst_n low one cycle mid-MEM -> FETCH with all flags 0.

Source files
------------

// File: rtl/mcpu_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV32I controller.
package mcpu_pkg;

    // Controller sequencing states
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_e;

    // Opcode constants (inst[6:2])
    localparam logic [4:0] OPC_R      = 5'b01100;
    localparam logic [4:0] OPC_I      = 5'b00100;
    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;
    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JAL    = 5'b11011;
    localparam logic [4:0] OPC_JALR   = 5'b11001;

    // ALU operation codes
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLT  = 4'd5,
        ALU_SLTU = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9
    } alu_e;

    // Instruction class captured in DECODE and used by later states
    typedef enum logic [3:0] {
        CLS_R      = 4'd0,
        CLS_I      = 4'd1,
        CLS_LUI    = 4'd2,
        CLS_AUIPC  = 4'd3,
        CLS_LOAD   = 4'd4,
        CLS_STORE  = 4'd5,
        CLS_BRANCH = 4'd6,
        CLS_JAL    = 4'd7,
        CLS_JALR   = 4'd8,
        CLS_ILL    = 4'd9
    } cls_e;

    // Immediate format select
    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    // PC source select
    localparam logic [1:0] JMP_PC4    = 2'b00;
    localparam logic [1:0] JMP_PCIMM  = 2'b01;
    localparam logic [1:0] JMP_RS1IMM = 2'b10;

    // Register write-back source select
    localparam logic [1:0] MTR_ALU = 2'b00;
    localparam logic [1:0] MTR_MEM = 2'b01;
    localparam logic [1:0] MTR_PC4 = 2'b10;

    // ALU operand A select
    localparam logic [1:0] SRCA_RS1  = 2'b00;
    localparam logic [1:0] SRCA_PC   = 2'b01;
    localparam logic [1:0] SRCA_ZERO = 2'b10;

    // Map an opcode onto its instruction class; anything unknown is illegal
    function automatic cls_e opc_class(input logic [4:0] opc);
        cls_e c;
        case (opc)
            OPC_R:      c = CLS_R;
            OPC_I:      c = CLS_I;
            OPC_LUI:    c = CLS_LUI;
            OPC_AUIPC:  c = CLS_AUIPC;
            OPC_LOAD:   c = CLS_LOAD;
            OPC_STORE:  c = CLS_STORE;
            OPC_BRANCH: c = CLS_BRANCH;
            OPC_JAL:    c = CLS_JAL;
            OPC_JALR:   c = CLS_JALR;
            default:    c = CLS_ILL;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mcpu_ctrl_if.sv
// Instruction-field inputs, memory handshake and datapath controls of the controller.
interface mcpu_ctrl_if #(
    parameter int ALUC_W = 4
) ();
    logic [4:0]        OPcode;
    logic [2:0]        Fun3;
    logic              Fun7;
    logic              MIO_ready;
    logic              CPU_MIO;
    logic              MemRW;
    logic              IRWrite;
    logic              PCWrite;
    logic              Branch;
    logic [1:0]        Jump;
    logic [2:0]        ImmSel;
    logic [1:0]        ALUSrc_A;
    logic              ALUSrc_B;
    logic [ALUC_W-1:0] ALU_Control;
    logic [1:0]        MemtoReg;
    logic              RegWrite;
    logic              illegal;
    logic              bus_err;

    // Controller side
    modport master (
        input  OPcode, Fun3, Fun7, MIO_ready,
        output CPU_MIO, MemRW, IRWrite, PCWrite, Branch, Jump, ImmSel,
               ALUSrc_A, ALUSrc_B, ALU_Control, MemtoReg, RegWrite, illegal, bus_err
    );

    // Datapath / memory side
    modport slave (
        output OPcode, Fun3, Fun7, MIO_ready,
        input  CPU_MIO, MemRW, IRWrite, PCWrite, Branch, Jump, ImmSel,
               ALUSrc_A, ALUSrc_B, ALU_Control, MemtoReg, RegWrite, illegal, bus_err
    );
endinterface

// File: rtl/mcpu_ctrl_alu_dec.sv
// Combinational ALU operation decoder for the instruction class and function fields.
module mcpu_alu_dec
    import mcpu_pkg::*;
(
    input  cls_e       cls,
    input  logic [2:0] fun3,
    input  logic       fun7,
    output alu_e       alu
);

    // R and I-ALU share the fun3 table; only R honours fun7 on ADD/SUB
    always_comb begin
        alu = ALU_ADD;
        case (cls)
            CLS_R, CLS_I: begin
                case (fun3)
                    3'b000:  alu = (cls == CLS_R && fun7) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu = ALU_SLL;
                    3'b010:  alu = ALU_SLT;
                    3'b011:  alu = ALU_SLTU;
                    3'b100:  alu = ALU_XOR;
                    3'b101:  alu = fun7 ? ALU_SRA : ALU_SRL;
                    3'b110:  alu = ALU_OR;
                    default: alu = ALU_AND;
                endcase
            end
            // BLTU/BGEU compare unsigned, the rest use subtraction
            CLS_BRANCH: alu = (fun3[2:1] == 2'b11) ? ALU_SLTU : ALU_SUB;
            default:    alu = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mcpu_ctrl.sv
// Multi-cycle RV32I control unit: FETCH/DECODE/EXEC/MEM/WB sequencing with bounded memory waits.
module mcpu_ctrl
    import mcpu_pkg::*;
#(
    parameter int ALUC_W   = 4,
    parameter int WAIT_MAX = 15,
    parameter int WAIT_W   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    mcpu_ctrl_if.master bus
);

    state_e             state_q, state_d;
    cls_e               cls_q, cls_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic               illegal_q, illegal_d;
    logic               bus_err_q, bus_err_d;

    alu_e               dec_alu;

    logic               cpu_mio, mem_rw, ir_write, pc_write, branch, alu_src_b, reg_write;
    logic [1:0]         jump, alu_src_a, mem_to_reg;
    logic [2:0]         imm_sel;
    logic [ALUC_W-1:0]  alu_ctrl;

    logic               timeout;

    mcpu_alu_dec u_alu_dec (
        .cls  (cls_q),
        .fun3 (bus.Fun3),
        .fun7 (bus.Fun7),
        .alu  (dec_alu)
    );

    // A pending access has waited its full budget and still has no ready
    assign timeout = !bus.MIO_ready && (wait_q == WAIT_W'(WAIT_MAX));

    // State, class, wait counter and sticky flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            cls_q     <= CLS_R;
            wait_q    <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            wait_q    <= wait_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
        end
    end

    // Next-state, wait-counter and sticky-flag logic
    always_comb begin
        state_d   = state_q;
        cls_d     = cls_q;
        illegal_d = illegal_q;
        bus_err_d = bus_err_q;
        wait_d    = '0;
        case (state_q)
            S_FETCH: begin
                if (bus.MIO_ready) begin
                    state_d = S_DECODE;
                end else if (timeout) begin
                    bus_err_d = 1'b1;
                    state_d   = S_TRAP;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_DECODE: begin
                cls_d = opc_class(bus.OPcode);
                if (cls_d == CLS_ILL) begin
                    illegal_d = 1'b1;
                    state_d   = S_TRAP;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                case (cls_q)
                    CLS_R, CLS_I, CLS_LUI, CLS_AUIPC: state_d = S_WB;
                    CLS_LOAD, CLS_STORE:              state_d = S_MEM;
                    default:                          state_d = S_FETCH;
                endcase
            end
            S_MEM: begin
                if (bus.MIO_ready) begin
                    state_d = (cls_q == CLS_LOAD) ? S_WB : S_FETCH;
                end else if (timeout) begin
                    bus_err_d = 1'b1;
                    state_d   = S_TRAP;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_WB:    state_d = S_FETCH;
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_TRAP;
        endcase
    end

    // Control outputs decoded from the registered state; forced idle while in reset
    always_comb begin
        cpu_mio    = 1'b0;
        mem_rw     = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        branch     = 1'b0;
        jump       = JMP_PC4;
        imm_sel    = IMM_I;
        alu_src_a  = SRCA_RS1;
        alu_src_b  = 1'b0;
        alu_ctrl   = ALUC_W'(ALU_ADD);
        mem_to_reg = MTR_ALU;
        reg_write  = 1'b0;
        if (rst_n) begin
            case (state_q)
                S_FETCH: begin
                    cpu_mio = 1'b1;
                    if (bus.MIO_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                    end
                end
                S_EXEC: begin
                    alu_ctrl = ALUC_W'(dec_alu);
                    case (cls_q)
                        CLS_R: alu_src_b = 1'b0;
                        CLS_I: alu_src_b = 1'b1;
                        CLS_LUI: begin
                            alu_src_a = SRCA_ZERO;
                            alu_src_b = 1'b1;
                            imm_sel   = IMM_U;
                        end
                        CLS_AUIPC: begin
                            alu_src_a = SRCA_PC;
                            alu_src_b = 1'b1;
                            imm_sel   = IMM_U;
                        end
                        CLS_LOAD: alu_src_b = 1'b1;
                        CLS_STORE: begin
                            alu_src_b = 1'b1;
                            imm_sel   = IMM_S;
                        end
                        CLS_BRANCH: begin
                            imm_sel = IMM_B;
                            branch  = 1'b1;
                            jump    = JMP_PCIMM;
                        end
                        CLS_JAL: begin
                            jump       = JMP_PCIMM;
                            imm_sel    = IMM_J;
                            pc_write   = 1'b1;
                            reg_write  = 1'b1;
                            mem_to_reg = MTR_PC4;
                        end
                        CLS_JALR: begin
                            jump       = JMP_RS1IMM;
                            pc_write   = 1'b1;
                            reg_write  = 1'b1;
                            mem_to_reg = MTR_PC4;
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    cpu_mio = 1'b1;
                    mem_rw  = (cls_q == CLS_STORE);
                end
                S_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = (cls_q == CLS_LOAD) ? MTR_MEM : MTR_ALU;
                end
                default: ;
            endcase
        end
    end

    assign bus.CPU_MIO     = cpu_mio;
    assign bus.MemRW       = mem_rw;
    assign bus.IRWrite     = ir_write;
    assign bus.PCWrite     = pc_write;
    assign bus.Branch      = branch;
    assign bus.Jump        = jump;
    assign bus.ImmSel      = imm_sel;
    assign bus.ALUSrc_A    = alu_src_a;
    assign bus.ALUSrc_B    = alu_src_b;
    assign bus.ALU_Control = alu_ctrl;
    assign bus.MemtoReg    = mem_to_reg;
    assign bus.RegWrite    = reg_write;
    assign bus.illegal     = illegal_q;
    assign bus.bus_err     = bus_err_q;

endmodule
